ram_alu_seq: RTL and testbench

- Parametrised successor to the small RAM-fronted ALU: a 2^AW-word operand register file plus a multi-cycle arithmetic engine.
- The host writes operands over a simple RAM port, then issues a start command naming two source words and an op.
- The engine runs an iterative shift-add multiply or restoring divide and pulses done with a registered 2*DW result.
- It sits on the same bus-style interface as the existing RAM/ALU blocks: one clock, level-sensitive we/re strobes.

---
 rtl/ram_alu_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_ram_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_alu_seq.sv
// rtl/ram_alu_seq.sv - operand RAM plus iterative multiply/divide engine
//
// ram_alu_seq: 2^AW x DW operand RAM with a multi-cycle arithmetic engine.
// The host loads operands through the RAM port, then pulses start with two
// RAM indices and an op. The engine latches operands (LOAD), runs DW
// shift-add or restoring-divide steps (EXEC), then pulses done (DONE) with
// a registered 2*DW result.
//
// Optional feature macro: RAM_ALU_OP_EXT_EN (enables ops 4-7 via op[2]).
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset (acts regardless of e)
//   e        clock enable; 0 freezes all state
//   w, r     RAM write / read strobes at addr
//   addr     RAM address
//   DIn      RAM write data
//   RdOut    registered RAM read data (1-cycle latency, holds when r=0)
//   start    command strobe, accepted in IDLE or DONE
//   op       operation select
//   a_sel    RAM index of X
//   b_sel    RAM index of Y
//   busy     engine in LOAD or EXEC
//   done     one-cycle result-valid pulse
//   DOut     result register, 2*DW bits
//   div_err  last result had a zero divisor
module ram_alu_seq #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            e,
  input  logic            w,
  input  logic            r,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   DIn,
  output logic [DW-1:0]   RdOut,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [AW-1:0]   a_sel,
  input  logic [AW-1:0]   b_sel,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] DOut,
  output logic            div_err
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

  state_t state, state_d;

  logic [DW-1:0]   mem [2**AW];
  logic [CW-1:0]   cnt;

  // Latched operation context
  logic            div_q;     // divide path active
  logic            rem_sel_q; // result is remainder (else quotient)
  logic            dz_q;      // divisor was zero
  logic            neg_q;     // negate product at the end
  logic [DW-1:0]   x_q;

  // Multiply datapath
  logic [2*DW-1:0] acc, mcand;
  logic [DW-1:0]   mplier;

  // Divide datapath
  logic [DW-1:0]   rem, quo, dvs;

  // Operand fetch and LOAD-time decode
  logic [DW-1:0]   xv, yv, mag;
  logic [DW:0]     sum, dfull;
  logic [2:0]      op_eff;
  logic            ld_div, ld_rem, ld_neg, ld_dz;
  logic [DW-1:0]   ld_dvs, ld_mplier;
  logic [2*DW-1:0] ld_acc, ld_mcand;

  // One EXEC step and final result
  logic [2*DW-1:0] prod_nx, res;
  logic [DW:0]     shifted;
  logic [DW-1:0]   rem_nx, quo_nx;
  logic            finish;

`ifndef RAM_ALU_OP_EXT_EN
  logic unused_op_hi;
  assign unused_op_hi = op[2];
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (e) begin
      state <= state_d;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        busy    = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand fetch and per-op initial values for the engine
  always_comb begin
    xv    = mem[a_sel];
    yv    = mem[b_sel];
    sum   = {1'b0, xv} + {1'b0, yv};
    dfull = {1'b0, xv} - {1'b0, yv};   // msb is the borrow, i.e. X < Y
    mag   = dfull[DW] ? (yv - xv) : dfull[DW-1:0];
`ifdef RAM_ALU_OP_EXT_EN
    op_eff = op;
`else
    op_eff = {1'b0, op[1:0]};
`endif
    ld_div    = 1'b0;
    ld_rem    = 1'b0;
    ld_neg    = 1'b0;
    ld_dvs    = yv;
    ld_acc    = '0;
    ld_mcand  = '0;
    ld_mplier = '0;
    case (op_eff)
      3'd0: begin
        ld_mcand  = {{(DW-1){1'b0}}, sum};
        ld_mplier = mag;
        ld_neg    = dfull[DW];
      end
      3'd1: begin
        ld_div = 1'b1;
        ld_rem = 1'b1;
      end
      3'd2: ld_div = 1'b1;
      3'd3: begin
        ld_div = 1'b1;
        ld_rem = 1'b1;
        ld_dvs = dfull[DW-1:0];
      end
`ifdef RAM_ALU_OP_EXT_EN
      // Ops 5-7 preload the answer with a zero multiplier so EXEC just
      // runs out the fixed latency.
      3'd4: begin
        ld_mcand  = {{DW{1'b0}}, xv};
        ld_mplier = yv;
      end
      3'd5: ld_acc = {{(DW-1){1'b0}}, sum};
      3'd6: ld_acc = {{(DW-1){dfull[DW]}}, dfull};
      3'd7: ld_acc = {{DW{1'b0}}, xv & yv};
`endif
      default: ;
    endcase
    ld_dz = ld_div && (ld_dvs == '0);
  end

  // One engine step and the value DOut takes on the final EXEC edge
  always_comb begin
    prod_nx = acc + (mplier[0] ? mcand : '0);
    shifted = {rem, quo[DW-1]};
    if (shifted >= {1'b0, dvs}) begin
      // The true difference is below dvs, so DW bits hold it exactly.
      rem_nx = shifted[DW-1:0] - dvs;
      quo_nx = {quo[DW-2:0], 1'b1};
    end else begin
      rem_nx = shifted[DW-1:0];
      quo_nx = {quo[DW-2:0], 1'b0};
    end
    if (div_q) begin
      if (rem_sel_q) res = {{DW{1'b0}}, dz_q ? x_q : rem_nx};
      else           res = {{DW{1'b0}}, dz_q ? {DW{1'b1}} : quo_nx};
    end else begin
      res = neg_q ? -prod_nx : prod_nx;
    end
    finish = (state == EXEC) && (cnt == LAST);
  end

  // RAM, engine datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      RdOut     <= '0;
      DOut      <= '0;
      div_err   <= 1'b0;
      cnt       <= '0;
      div_q     <= 1'b0;
      rem_sel_q <= 1'b0;
      dz_q      <= 1'b0;
      neg_q     <= 1'b0;
      x_q       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
    end else if (e) begin
      if (w) mem[addr] <= DIn;
      if (r) RdOut <= mem[addr];   // old data on same-address write

      if (state == LOAD) begin
        cnt       <= '0;
        div_q     <= ld_div;
        rem_sel_q <= ld_rem;
        dz_q      <= ld_dz;
        neg_q     <= ld_neg;
        x_q       <= xv;
        acc       <= ld_acc;
        mcand     <= ld_mcand;
        mplier    <= ld_mplier;
        rem       <= '0;
        quo       <= xv;
        dvs       <= ld_dvs;
      end else if (state == EXEC) begin
        cnt <= cnt + 1'b1;
        if (div_q) begin
          rem <= rem_nx;
          quo <= quo_nx;
        end else begin
          acc    <= prod_nx;
          mcand  <= {mcand[2*DW-2:0], 1'b0};
          mplier <= {1'b0, mplier[DW-1:1]};
        end
      end

      if (finish) begin
        DOut    <= res;
        div_err <= div_q & dz_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_alu_seq.sv
// tb/tb_ram_alu_seq.sv - directed self-checking bench for ram_alu_seq
module tb_ram_alu_seq;
  logic        clk = 1'b0;
  logic        rst, e, w, r, start;
  logic [2:0]  addr, a_sel, b_sel, op;
  logic [15:0] DIn, RdOut;
  logic        busy, done, div_err;
  logic [31:0] DOut;

  int checks = 0;
  int errors = 0;
  int cyc, bc, nd;

  ram_alu_seq dut (
    .clk(clk), .rst(rst), .e(e), .w(w), .r(r), .addr(addr), .DIn(DIn),
    .RdOut(RdOut), .start(start), .op(op), .a_sel(a_sel), .b_sel(b_sel),
    .busy(busy), .done(done), .DOut(DOut), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    w = 1'b1; addr = a; DIn = d;
    tick();
    w = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    r = 1'b1; addr = a;
    tick();
    r = 1'b0;
  endtask

  task automatic go(input logic [2:0] o, input logic [2:0] xa, input logic [2:0] ya);
    start = 1'b1; op = o; a_sel = xa; b_sel = ya;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int b);
    n = 0;
    b = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) b++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] exp_d, input logic exp_e);
    go(o, 3'd0, 3'd1);
    wait_done(cyc, bc);
    chk({tag, "_lat"}, cyc, 17);
    chk({tag, "_dout"}, DOut, exp_d);
    chk({tag, "_err"}, {31'd0, div_err}, {31'd0, exp_e});
  endtask

  task automatic count_done(input int n);
    nd = 0;
    repeat (n) begin
      tick();
      if (done === 1'b1) nd++;
    end
  endtask

  initial begin
    rst = 1'b1; e = 1'b1; w = 1'b0; r = 1'b0; start = 1'b0;
    addr = '0; DIn = '0; op = '0; a_sel = '0; b_sel = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, div_err}, 32'd0);
    chk("rst_dout", DOut, 32'd0);
    chk("rst_rdout", {16'd0, RdOut}, 32'd0);

    // (4+5)*(4-5) = -9
    wr(3'd0, 16'd4);
    wr(3'd1, 16'd5);
    go(3'd0, 3'd0, 3'd1);
    chk("op0_busy_start", {31'd0, busy}, 32'd1);
    wait_done(cyc, bc);
    chk("op0_lat", cyc, 17);
    chk("op0_busy_cycles", bc, 17);
    chk("op0_busy_at_done", {31'd0, busy}, 32'd0);
    chk("op0_dout", DOut, 32'hFFFF_FFF7);
    chk("op0_err", {31'd0, div_err}, 32'd0);
    tick();
    chk("op0_done_pulse", {31'd0, done}, 32'd0);

    // Divide family
    wr(3'd0, 16'd445);
    wr(3'd1, 16'd100);
    run_op("op1", 3'd1, 32'd45, 1'b0);
    run_op("op2", 3'd2, 32'd4, 1'b0);
    run_op("op3", 3'd3, 32'd100, 1'b0);
    wr(3'd0, 16'd1000);
    wr(3'd1, 16'd250);
    run_op("op3b", 3'd3, 32'd250, 1'b0);
    wr(3'd1, 16'd1000);
    run_op("op3_dz", 3'd3, 32'd1000, 1'b1);
    wr(3'd1, 16'd0);
    run_op("op2_dz", 3'd2, 32'h0000_FFFF, 1'b1);

    // Start ignored during EXEC, write during EXEC not seen by the engine
    wr(3'd0, 16'd4);
    wr(3'd1, 16'd5);
    go(3'd0, 3'd0, 3'd1);
    repeat (5) tick();
    start = 1'b1; op = 3'd2; w = 1'b1; addr = 3'd0; DIn = 16'd7;
    tick();
    start = 1'b0; w = 1'b0;
    wait_done(cyc, bc);
    chk("ign_lat", 6 + cyc, 17);
    chk("ign_dout", DOut, 32'hFFFF_FFF7);
    count_done(30);
    chk("ign_single_done", nd, 0);
    rd(3'd0);
    chk("ign_readback", {16'd0, RdOut}, 32'd7);

    // Same-address read and write returns old data; RdOut holds with r=0
    r = 1'b1; w = 1'b1; addr = 3'd0; DIn = 16'd9;
    tick();
    r = 1'b0; w = 1'b0;
    chk("rw_old", {16'd0, RdOut}, 32'd7);
    tick();
    chk("rd_hold", {16'd0, RdOut}, 32'd7);
    rd(3'd0);
    chk("rw_new", {16'd0, RdOut}, 32'd9);

    // Back-to-back: start accepted in the DONE cycle
    wr(3'd0, 16'd4);
    go(3'd0, 3'd0, 3'd1);
    wait_done(cyc, bc);
    chk("b2b_first", DOut, 32'hFFFF_FFF7);
    start = 1'b1; op = 3'd1;
    tick();
    start = 1'b0;
    wait_done(cyc, bc);
    chk("b2b_gap", 1 + cyc, 18);
    chk("b2b_dout", DOut, 32'd4);

    // Reset in EXEC cycle 5 aborts
    go(3'd0, 3'd0, 3'd1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_dout", DOut, 32'd0);
    rd(3'd1);
    chk("mid_rst_ram", {16'd0, RdOut}, 32'd0);
    count_done(30);
    chk("mid_rst_no_done", nd, 0);

    // Clock enable low for 10 cycles stretches latency by 10
    wr(3'd0, 16'd4);
    wr(3'd1, 16'd5);
    go(3'd0, 3'd0, 3'd1);
    repeat (4) tick();
    e = 1'b0;
    repeat (10) tick();
    chk("e_hold_busy", {31'd0, busy}, 32'd1);
    e = 1'b1;
    wait_done(cyc, bc);
    chk("e_lat", 14 + cyc, 27);
    chk("e_dout", DOut, 32'hFFFF_FFF7);

    // Extended ops, or op[2] ignored without them
    wr(3'd0, 16'd300);
    wr(3'd1, 16'd400);
`ifdef RAM_ALU_OP_EXT_EN
    run_op("op6", 3'd6, 32'hFFFF_FF9C, 1'b0);
    run_op("op4", 3'd4, 32'd120000, 1'b0);
    run_op("op5", 3'd5, 32'd700, 1'b0);
    run_op("op7", 3'd7, 32'd256, 1'b0);
`else
    run_op("op6_as_op2", 3'd6, 32'd0, 1'b0);
    run_op("op5_as_op1", 3'd5, 32'd300, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
